sequence_detector_prog: RTL and testbench
=========================================

Name: sequence_detector_prog

Overview:
- Runtime-programmable serial pattern detector; parametrised successor to the fixed 4-bit "0110" non-overlapping detector.
- Pattern length is 1..MAX_LEN and the pattern bits are loadable, so there is no need to hand-write one FSM per pattern.
- Overlapping/non-overlapping mode is selectable. Input is qualified by valid_in, and a saturating match counter is provided.
- Sits between a serial bit source and control/status logic.
- Reset defaults reproduce the "0110" non-overlapping detector exactly.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of match_count.
- DEF_PATTERN, 8'b0000_0110, reset pattern (LSB-aligned, width MAX_LEN).
- DEF_LEN, 4, reset pattern length.
- DEF_OVERLAP, 1'b0, reset mode (0 = non-overlapping).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  one-cycle strobe that latches cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection.
- clear_count  in  1  synchronous clear of match_count.
- valid_in  in  1  data_in is sampled only when high.
- data_in  in  1  serial data bit.
- detected  out  1  one-cycle pulse, registered.
- match_count  out  CNT_W  saturating count of detections.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Shadow regs load DEF_PATTERN/DEF_LEN/DEF_OVERLAP; history and fill count clear.
  - detected=0, match_count=0, state=IDLE.
- Shadow config:
  - On cfg_load, latch the cfg_* inputs.
  - cfg_len > MAX_LEN saturates to MAX_LEN.
  - cfg_len == 0 leaves the block in IDLE with no detections.
  - cfg_load also clears history and fill count, and sends the FSM to IDLE (len=0) or FILL.
  - cfg_load has priority over a same-cycle valid_in beat; that bit is discarded.
  - match_count is not affected by cfg_load.
- History: MAX_LEN-bit shift register. On each valid beat, hist <= {hist[MAX_LEN-2:0], data_in}. fill_cnt increments, saturating at MAX_LEN.
- Match condition: a valid beat whose updated history satisfies both:
  - (hist_next & mask) == (pattern & mask), where mask = low len bits set;
  - fill_next >= len.
- FSM (state_t):
  - IDLE (00): len==0; moves to FILL on a cfg_load with len>0.
  - FILL (01): fill_cnt < len; moves to HUNT when fill_next >= len.
  - HUNT (10): compare on each valid beat.
  - MATCH (11): entered for exactly the cycle after a matching beat.
  - MATCH exits to HUNT or FILL per the mode rule below, evaluated on that cycle's beat.
- Output timing:
  - detected=1 while in MATCH, i.e. one cycle after the final matching bit is sampled.
  - Back-to-back matches (overlap mode, e.g. len=1) keep detected high on consecutive cycles.
- Non-overlapping mode (cfg_overlap=0):
  - On a match, fill_cnt is cleared to 0, so matched bits cannot be reused.
  - The next detection needs len fresh bits.
  - This matches the legacy fixed FSM, including the "0110"→"0" restart behaviour.
- Overlapping mode (cfg_overlap=1): on a match, fill_cnt is retained and the next match can share the suffix.
- valid_in low: history, fill_cnt and state hold. MATCH still returns to HUNT/FILL after one cycle, so detected is a single-cycle pulse.
- match_count:
  - Increments on each cycle where detected is asserted, saturating at 2^CNT_W-1.
  - clear_count wins over a same-cycle increment.
- Reset mid-stream: history is discarded immediately and the configuration reverts to the defaults.

Decomposition:
- Package seq_det_pkg holds:
  - state_t enum {IDLE, FILL, HUNT, MATCH};
  - function len_mask(len) returning the low-len-bits mask;
  - function sat_len(len).
- One sub-module, seq_det_shift_hist: history shift register plus saturating fill counter, with inputs shift_en, clr, data_in and outputs hist, fill_cnt.
- The top level holds the config shadow, compare, FSM and counter.

Test Plan:
- After reset, no cfg_load, stream valid bits 0,1,1,0,1,1,0 → detected pulses once, one cycle after the 4th bit. The 7th bit does not trigger because the shared 0 is not reused. match_count=1.
- cfg_load pattern=0110, len=4, overlap=1; stream 0,1,1,0,1,1,0 → pulses after bit 4 and bit 7; match_count=2.
- cfg_load pattern=8'b1011_0011, len=8, overlap=0; stream that pattern with valid_in toggled low every other cycle → exactly one pulse, after the 8th valid bit; gaps do not break the match.
- cfg_load len=1, pattern=1, overlap=1; five consecutive valid 1s → detected high for 5 consecutive cycles; match_count=5.
- Assert cfg_load (len=3, pattern=101) in the same cycle as a valid 0 → that bit is ignored; stream 1,0,1 → one pulse. A cfg_len=0 load afterwards → no detections for any stream, state_o=00.
- Preload CNT_W=4 (count=15) and continue matching → holds at 15. Assert clear_count with a same-cycle match → count=0. Pull reset_n low mid-pattern → outputs clear immediately and the defaults are restored.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// len_mask returns a wide mask; callers size-cast it down to their pattern width.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        HUNT  = 2'b10,
        MATCH = 2'b11
    } state_t;

    localparam int MASK_W = 64;

    function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (32'(i) < len);
        end
        return m;
    endfunction

    function automatic logic [31:0] sat_len(input logic [31:0] len, input logic [31:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_shift_hist.sv
// Serial history shift register with a fill counter that saturates at MAX_LEN.
// restart zeroes the fill count while still shifting in the current bit.
module seq_det_shift_hist
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             shift_en,
    input  logic                             clr,
    input  logic                             restart,
    input  logic                             data_in,
    output logic [MAX_LEN-1:0]               hist,
    output logic [$clog2(MAX_LEN+1)-1:0]     fill_cnt,
    output logic [MAX_LEN-1:0]               hist_next,
    output logic [$clog2(MAX_LEN+1)-1:0]     fill_next
);
    localparam int FILL_W = $clog2(MAX_LEN+1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(MAX_LEN);

    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], data_in};
        fill_next = (fill_cnt == FULL) ? fill_cnt : fill_cnt + FILL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist     <= '0;
            fill_cnt <= '0;
        end else if (clr) begin
            hist     <= '0;
            fill_cnt <= '0;
        end else if (shift_en) begin
            hist     <= hist_next;
            fill_cnt <= restart ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/sequence_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap mode and a saturating match counter.
// Reset defaults behave as the legacy non-overlapping "0110" detector.
module sequence_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int                 DEF_LEN     = 4,
    parameter logic               DEF_OVERLAP = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           clear_count,
    input  logic                           valid_in,
    input  logic                           data_in,
    output logic                           detected,
    output logic [CNT_W-1:0]               match_count,
    output logic [1:0]                     state_o
);
    localparam int LEN_W = $clog2(MAX_LEN+1);
    localparam logic [LEN_W-1:0] DEF_LEN_SAT = LEN_W'(sat_len(32'(DEF_LEN), 32'(MAX_LEN)));

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    state_t             state;

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_cnt;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_sat;
    logic               beat;
    logic               hit;
    logic               restart;

    // A config load swallows any same-cycle data beat.
    assign beat        = valid_in & ~cfg_load;
    assign cfg_len_sat = LEN_W'(sat_len(32'(cfg_len), 32'(MAX_LEN)));
    assign mask        = MAX_LEN'(len_mask(32'(len_q)));
    assign hit         = beat && (len_q != '0) && (fill_next >= len_q) &&
                         (((hist_next ^ pattern_q) & mask) == '0);
    assign restart     = hit & ~overlap_q;
    assign state_o     = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN_SAT;
            overlap_q <= DEF_OVERLAP;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_sat;
            overlap_q <= cfg_overlap;
        end
    end

    seq_det_shift_hist #(
        .MAX_LEN (MAX_LEN)
    ) u_hist (
        .clk       (clk),
        .reset_n   (reset_n),
        .shift_en  (beat),
        .clr       (cfg_load),
        .restart   (restart),
        .data_in   (data_in),
        .hist      (hist),
        .fill_cnt  (fill_cnt),
        .hist_next (hist_next),
        .fill_next (fill_next)
    );

    // IDLE after reset still hunts when the default length is nonzero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            detected <= 1'b0;
        end else if (cfg_load) begin
            state    <= (cfg_len_sat == '0) ? IDLE : FILL;
            detected <= 1'b0;
        end else if (len_q == '0) begin
            state    <= IDLE;
            detected <= 1'b0;
        end else if (hit) begin
            state    <= MATCH;
            detected <= 1'b1;
        end else begin
            detected <= 1'b0;
            if (beat) begin
                state <= (fill_next >= len_q) ? HUNT : FILL;
            end else if (state == MATCH) begin
                state <= (fill_cnt >= len_q) ? HUNT : FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_count <= '0;
        end else if (clear_count) begin
            match_count <= '0;
        end else if (detected && (match_count != '1)) begin
            match_count <= match_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sequence_detector_prog.sv
// Directed bench for sequence_detector_prog; a second instance with a 4-bit counter checks saturation.
module tb_sequence_detector_prog;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN+1);

    logic               clk;
    logic               reset_n;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clear_count;
    logic               valid_in;
    logic               data_in;
    logic               detected;
    logic [15:0]        match_count;
    logic [1:0]         state_o;
    logic               detected_sat;
    logic [3:0]         match_count_sat;
    logic [1:0]         state_sat;

    int checks;
    int failures;
    logic [31:0] dv;
    int ndet;
    int nbad;
    logic [7:0] pat;

    sequence_detector_prog dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clear_count (clear_count),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .detected    (detected),
        .match_count (match_count),
        .state_o     (state_o)
    );

    sequence_detector_prog #(.CNT_W(4)) dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clear_count (clear_count),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .detected    (detected_sat),
        .match_count (match_count_sat),
        .state_o     (state_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic applyConfig(input logic [7:0] p, input int l, input logic ov, input logic v, input logic d);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = ov;
        cfg_load    = 1'b1;
        valid_in    = v;
        data_in     = d;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic clearCount();
        clear_count = 1'b1;
        @(posedge clk);
        #1;
        clear_count = 1'b0;
    endtask

    // First bit sent is bits[n-1]; det_vec collects detected after each beat in the same order.
    task automatic runStream(input logic [31:0] bits, input int n, output logic [31:0] det_vec);
        det_vec = '0;
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i]);
            det_vec = {det_vec[30:0], detected};
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        clear_count = 1'b0;
        valid_in    = 1'b0;
        data_in     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_detected", 32'(detected), 32'd0);
        checkOutput("rst_count", 32'(match_count), 32'd0);
        checkOutput("rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Defaults: non-overlapping 0110
        runStream(32'b0110110, 7, dv);
        checkOutput("def_det_vec", dv, 32'b0001000);
        checkOutput("def_state", 32'(state_o), 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("def_count", 32'(match_count), 32'd1);

        // Overlapping 0110
        clearCount();
        applyConfig(8'b0000_0110, 4, 1'b1, 1'b0, 1'b0);
        checkOutput("ovl_state_after_load", 32'(state_o), 32'd1);
        runStream(32'b0110110, 7, dv);
        checkOutput("ovl_det_vec", dv, 32'b0001001);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ovl_count", 32'(match_count), 32'd2);

        // Length 8 with idle gaps between valid bits
        clearCount();
        pat = 8'b1011_0011;
        applyConfig(pat, 8, 1'b0, 1'b0, 1'b0);
        ndet = 0;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, pat[i]);
            if (i == 0) checkOutput("gap_det_final", 32'(detected), 32'd1);
            else ndet += int'(detected);
            applyStimulus(1'b0, ~pat[i]);
            ndet += int'(detected);
        end
        checkOutput("gap_extra_dets", 32'(ndet), 32'd0);
        checkOutput("gap_count", 32'(match_count), 32'd1);
        checkOutput("gap_state", 32'(state_o), 32'd1);

        // Oversized cfg_len saturates to MAX_LEN
        applyConfig(pat, 12, 1'b0, 1'b0, 1'b0);
        runStream(32'(pat), 8, dv);
        checkOutput("satlen_det_vec", dv, 32'b0000_0001);
        checkOutput("satlen_state", 32'(state_o), 32'd3);
        applyStimulus(1'b0, 1'b0);

        // len=1 back-to-back matches
        clearCount();
        applyConfig(8'h01, 1, 1'b1, 1'b0, 1'b0);
        runStream(32'b11111, 5, dv);
        checkOutput("len1_det_vec", dv, 32'b11111);
        applyStimulus(1'b0, 1'b0);
        checkOutput("len1_det_after", 32'(detected), 32'd0);
        checkOutput("len1_count", 32'(match_count), 32'd5);

        // cfg_load discards a same-cycle valid bit
        clearCount();
        applyConfig(8'b0000_0101, 3, 1'b0, 1'b1, 1'b1);
        runStream(32'b0101, 4, dv);
        checkOutput("ldprio_det_vec", dv, 32'b0001);
        applyStimulus(1'b0, 1'b0);
        checkOutput("ldprio_count", 32'(match_count), 32'd1);

        // Zero length: IDLE forever
        applyConfig(8'h00, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("len0_state_load", 32'(state_o), 32'd0);
        ndet = 0;
        nbad = 0;
        pat  = 8'b1011_0100;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, pat[i]);
            ndet += int'(detected);
            if (state_o != 2'b00) nbad++;
        end
        checkOutput("len0_dets", 32'(ndet), 32'd0);
        checkOutput("len0_non_idle", 32'(nbad), 32'd0);

        // Counter saturation and clear priority
        clearCount();
        applyConfig(8'h01, 1, 1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sat_count_wide", 32'(match_count), 32'd20);
        checkOutput("sat_count_narrow", 32'(match_count_sat), 32'd15);
        applyStimulus(1'b1, 1'b1);
        checkOutput("clr_det_before", 32'(detected), 32'd1);
        clear_count = 1'b1;
        applyStimulus(1'b0, 1'b0);
        clear_count = 1'b0;
        checkOutput("clr_count_wide", 32'(match_count), 32'd0);
        checkOutput("clr_count_narrow", 32'(match_count_sat), 32'd0);

        // Asynchronous reset mid-stream restores defaults
        applyConfig(8'b0000_0101, 3, 1'b1, 1'b0, 1'b0);
        runStream(32'b10101, 5, dv);
        checkOutput("mid_det_vec", dv, 32'b00101);
        checkOutput("mid_count_pre", 32'(match_count), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_det", 32'(detected), 32'd0);
        checkOutput("mid_rst_count", 32'(match_count), 32'd0);
        checkOutput("mid_rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        runStream(32'b0110110, 7, dv);
        checkOutput("post_rst_det_vec", dv, 32'b0001000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
